// File: rtl/zap_wb_pkg.sv
// Shared Wishbone constants and types for the ZAP instruction/data bus arbiter.
package zap_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} zap_wb_gnt_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        wen;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } zap_wb_req_t;

  function automatic zap_wb_gnt_t other_master(input zap_wb_gnt_t g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/zap_wb_rr_grant.sv
// Round-robin ownership FSM: tracks the bus owner and the last master to finish a cycle,
// and only hands the bus over at a cycle boundary.
module zap_wb_rr_grant
  import zap_wb_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_ic_cyc_nxt,
  input  logic i_dc_cyc_nxt,
  input  logic i_wb_cyc,
  input  logic i_wb_stb,
  input  logic i_wb_ack,
  output logic o_grant,
  output logic o_grant_nxt
);

  zap_wb_gnt_t grant_q, grant_d;
  zap_wb_gnt_t last_q, last_d;
  logic        owner_cyc_nxt;
  logic        other_cyc_nxt;
  logic        window_open;

  always_comb begin
    owner_cyc_nxt = (grant_q == GNT_I) ? i_ic_cyc_nxt : i_dc_cyc_nxt;
    other_cyc_nxt = (grant_q == GNT_I) ? i_dc_cyc_nxt : i_ic_cyc_nxt;
    // The current beat must be finished (or absent) and the owner done with its cycle.
    window_open   = (!i_wb_stb || i_wb_ack) && !owner_cyc_nxt;

    grant_d = grant_q;
    last_d  = last_q;

    if (!i_wb_cyc && i_ic_cyc_nxt && i_dc_cyc_nxt) begin
      grant_d = other_master(last_q);
    end else if (window_open && other_cyc_nxt) begin
      grant_d = other_master(grant_q);
    end

    if (i_wb_cyc && !owner_cyc_nxt) begin
      last_d = grant_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      grant_q <= GNT_I;
      last_q  <= GNT_I;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_grant_nxt = grant_d;

endmodule

// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone arbiter: muxes the I-side/D-side next-cycle requests into one
// registered master port and routes ACK/read data back to the current owner.
module zap_wb_arbiter
  import zap_wb_pkg::*;
#(
  parameter int STRAY_CNT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,

  input  logic                   i_ic_wb_cyc_nxt,
  input  logic                   i_ic_wb_stb_nxt,
  input  logic                   i_ic_wb_wen_nxt,
  input  logic [3:0]             i_ic_wb_sel_nxt,
  input  logic [31:0]            i_ic_wb_adr_nxt,
  input  logic [31:0]            i_ic_wb_dat_nxt,
  input  logic [2:0]             i_ic_wb_cti_nxt,

  input  logic                   i_dc_wb_cyc_nxt,
  input  logic                   i_dc_wb_stb_nxt,
  input  logic                   i_dc_wb_wen_nxt,
  input  logic [3:0]             i_dc_wb_sel_nxt,
  input  logic [31:0]            i_dc_wb_adr_nxt,
  input  logic [31:0]            i_dc_wb_dat_nxt,
  input  logic [2:0]             i_dc_wb_cti_nxt,

  output logic                   o_ic_wb_ack,
  output logic                   o_dc_wb_ack,
  output logic [31:0]            o_ic_wb_dat,
  output logic [31:0]            o_dc_wb_dat,

  output logic                   o_wb_cyc,
  output logic                   o_wb_stb,
  output logic                   o_wb_wen,
  output logic [3:0]             o_wb_sel,
  output logic [31:0]            o_wb_adr,
  output logic [31:0]            o_wb_dat,
  output logic [2:0]             o_wb_cti,
  input  logic [31:0]            i_wb_dat,
  input  logic                   i_wb_ack,

  output logic                   o_grant,
  output logic [STRAY_CNT_W-1:0] o_stray_ack_cnt
);

  zap_wb_req_t            ic_req;
  zap_wb_req_t            dc_req;
  zap_wb_req_t            bus_d, bus_q;
  logic                   grant_q;
  logic                   grant_d;
  logic                   stray_ack;
  logic [STRAY_CNT_W-1:0] stray_cnt_d, stray_cnt_q;

  zap_wb_rr_grant u_rr_grant (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_ic_cyc_nxt (i_ic_wb_cyc_nxt),
    .i_dc_cyc_nxt (i_dc_wb_cyc_nxt),
    .i_wb_cyc     (bus_q.cyc),
    .i_wb_stb     (bus_q.stb),
    .i_wb_ack     (i_wb_ack),
    .o_grant      (grant_q),
    .o_grant_nxt  (grant_d)
  );

  always_comb begin
    ic_req = '{cyc: i_ic_wb_cyc_nxt, stb: i_ic_wb_stb_nxt, wen: i_ic_wb_wen_nxt,
               sel: i_ic_wb_sel_nxt, adr: i_ic_wb_adr_nxt, dat: i_ic_wb_dat_nxt,
               cti: i_ic_wb_cti_nxt};
    dc_req = '{cyc: i_dc_wb_cyc_nxt, stb: i_dc_wb_stb_nxt, wen: i_dc_wb_wen_nxt,
               sel: i_dc_wb_sel_nxt, adr: i_dc_wb_adr_nxt, dat: i_dc_wb_dat_nxt,
               cti: i_dc_wb_cti_nxt};
    // Selecting with the next grant lets a handover land on the bus with no idle cycle.
    bus_d = grant_d ? dc_req : ic_req;

    stray_ack   = i_wb_ack && !bus_q.stb;
    stray_cnt_d = stray_cnt_q;
    if (stray_ack && (stray_cnt_q != {STRAY_CNT_W{1'b1}})) begin
      stray_cnt_d = stray_cnt_q + STRAY_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bus_q       <= '{cti: CTI_CLASSIC, default: '0};
      stray_cnt_q <= '0;
    end else begin
      bus_q       <= bus_d;
      stray_cnt_q <= stray_cnt_d;
    end
  end

  assign o_wb_cyc = bus_q.cyc;
  assign o_wb_stb = bus_q.stb;
  assign o_wb_wen = bus_q.wen;
  assign o_wb_sel = bus_q.sel;
  assign o_wb_adr = bus_q.adr;
  assign o_wb_dat = bus_q.dat;
  assign o_wb_cti = bus_q.cti;

  assign o_ic_wb_ack = i_wb_ack & bus_q.stb & ~grant_q;
  assign o_dc_wb_ack = i_wb_ack & bus_q.stb &  grant_q;
  assign o_ic_wb_dat = i_wb_dat;
  assign o_dc_wb_dat = i_wb_dat;

  assign o_grant         = grant_q;
  assign o_stray_ack_cnt = stray_cnt_q;

endmodule
